// File: rtl/mont_mul_serial_if.sv
// Start/done handshake bundle between the exponentiation ladder (master)
// and the bit-serial Montgomery multiplier (slave).
// N is the operand/modulus width and must match the attached multiplier.
interface mont_mul_serial_if #(
    parameter int N = 1024
) ();
    logic         start;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic [N-1:0] in_m;
    logic [N-1:0] result;
    logic         done;

    modport master (
        output start,
        output in_a,
        output in_b,
        output in_m,
        input  result,
        input  done
    );

    modport slave (
        input  start,
        input  in_a,
        input  in_b,
        input  in_m,
        output result,
        output done
    );
endinterface

// File: rtl/mont_mul_serial.sv
// Bit-serial radix-2 Montgomery multiplier: result = A*B*2^-N mod M.
// One bit of A is consumed per clock. B+M is precomputed once per operation
// so every loop step needs a single adder pass (T + {0, B, M, B+M}).
//
// Configuration macro: MONT_FINAL_SUB_EN
//   defined   : a final conditional subtraction state reduces the result to
//               0 <= result < M; done follows the accepting edge by N+2 edges.
//   undefined : the subtraction is skipped, result < 2M (congruent mod M),
//               done follows by N+1 edges; requires M < 2^(N-1).
//
// resetn is asynchronous active-low and also serves as the per-operation
// abort used by the ladder: an aborted operation never pulses done.
module mont_mul_serial #(
    parameter int N  = 1024,
    parameter int CW = 11
) (
    input  logic               clk,
    input  logic               resetn,
    mont_mul_serial_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_LOOP = 2'd2,
        S_SUB  = 2'd3
    } state_e;

    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    state_e        state_q;
    state_e        state_d;

    // Captured operands; a_q shifts right so the current bit is always a_q[0].
    logic [N-1:0]  a_q;
    logic [N-1:0]  a_d;
    logic [N-1:0]  b_q;
    logic [N-1:0]  b_d;
    logic [N-1:0]  m_q;
    logic [N-1:0]  m_d;
    logic [N:0]    bm_q;
    logic [N:0]    bm_d;
    logic [N:0]    t_q;
    logic [N:0]    t_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [N-1:0]  result_q;
    logic [N-1:0]  result_d;
    logic          done_q;
    logic          done_d;

    logic          q_s;
    logic [1:0]    sel_s;
    logic [N:0]    addend_s;
    logic [N:0]    t_next_s;
    logic          last_iter_s;
`ifdef MONT_FINAL_SUB_EN
    logic          t_ge_m_s;
    logic [N-1:0]  t_minus_m_s;
`endif

    assign bus.result = result_q;
    assign bus.done   = done_q;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Loop step arithmetic: pick the addend so T + addend is even, then halve.
    always_comb begin
        q_s   = a_q[0];
        sel_s = {q_s, t_q[0] ^ (q_s & b_q[0])};
        case (sel_s)
            2'b00:   addend_s = {(N+1){1'b0}};
            2'b10:   addend_s = {1'b0, b_q};
            2'b01:   addend_s = {1'b0, m_q};
            2'b11:   addend_s = bm_q;
            default: addend_s = {(N+1){1'b0}};
        endcase
        // (T + addend) is even, so the carry out of bit 0 is T[0] & addend[0];
        // halving is folded into the add to keep the adder N+1 bits wide here.
        t_next_s = {1'b0, t_q[N:1]} + {1'b0, addend_s[N:1]}
                 + {{N{1'b0}}, (t_q[0] & addend_s[0])};
        last_iter_s = (cnt_q == LAST_CNT);
`ifdef MONT_FINAL_SUB_EN
        t_ge_m_s    = (t_q >= {1'b0, m_q});
        // T < 2M, so when T >= M the difference fits N bits.
        t_minus_m_s = t_q[N-1:0] - m_q;
`endif
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_PRE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRE: begin
                state_d = S_LOOP;
            end
            S_LOOP: begin
                if (last_iter_s) begin
`ifdef MONT_FINAL_SUB_EN
                    state_d = S_SUB;
`else
                    state_d = S_IDLE;
`endif
                end else begin
                    state_d = S_LOOP;
                end
            end
            S_SUB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath and output next values per state.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        bm_d     = bm_q;
        t_d      = t_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d = bus.in_a;
                    b_d = bus.in_b;
                    m_d = bus.in_m;
                end else begin
                    a_d = a_q;
                end
            end
            S_PRE: begin
                bm_d  = {1'b0, b_q} + {1'b0, m_q};
                t_d   = {(N+1){1'b0}};
                cnt_d = {CW{1'b0}};
            end
            S_LOOP: begin
                t_d   = t_next_s;
                a_d   = {1'b0, a_q[N-1:1]};
                cnt_d = cnt_q + CW'(1);
`ifndef MONT_FINAL_SUB_EN
                if (last_iter_s) begin
                    result_d = t_next_s[N-1:0];
                    done_d   = 1'b1;
                end else begin
                    done_d   = 1'b0;
                end
`endif
            end
`ifdef MONT_FINAL_SUB_EN
            S_SUB: begin
                if (t_ge_m_s) begin
                    result_d = t_minus_m_s;
                end else begin
                    result_d = t_q[N-1:0];
                end
                done_d = 1'b1;
            end
`endif
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_q      <= {N{1'b0}};
            b_q      <= {N{1'b0}};
            m_q      <= {N{1'b0}};
            bm_q     <= {(N+1){1'b0}};
            t_q      <= {(N+1){1'b0}};
            cnt_q    <= {CW{1'b0}};
            result_q <= {N{1'b0}};
            done_q   <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            bm_q     <= bm_d;
            t_q      <= t_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_mont_mul_serial.sv
// Self-checking bench for mont_mul_serial: an N=8 instance for directed
// handshake/abort cases plus random vectors, and an N=1024 instance for
// random vectors with A = 2^N mod M (Montgomery identity).
// Reference: T = (A*B + u*M) / 2^N with u = -A*B*M^-1 mod 2^N, optionally
// reduced once by M.
module tb_mont_mul_serial;

    localparam int N8  = 8;
    localparam int CW8 = 4;
    localparam int N1K = 1024;
    localparam int CW1K = 11;
    localparam int W   = 2112;
`ifdef MONT_FINAL_SUB_EN
    localparam int EXTRA    = 2;
    localparam bit FULL_SUB = 1'b1;
`else
    localparam int EXTRA    = 1;
    localparam bit FULL_SUB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst8_n;
    logic rst1k_n;

    always #5 clk = ~clk;

    mont_mul_serial_if #(.N(N8))  if8 ();
    mont_mul_serial_if #(.N(N1K)) if1k ();

    mont_mul_serial #(.N(N8), .CW(CW8)) dut8 (
        .clk    (clk),
        .resetn (rst8_n),
        .bus    (if8.slave)
    );

    mont_mul_serial #(.N(N1K), .CW(CW1K)) dut1k (
        .clk    (clk),
        .resetn (rst1k_n),
        .bus    (if1k.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0]    prev8;
    logic [1023:0] prev1k;

    function automatic logic [1024:0] mont_ref(input logic [1023:0] a, input logic [1023:0] b,
                                               input logic [1023:0] m, input int n);
        logic [W-1:0] mask, inv, ab, u, t, mw, two;
        mw   = W'(m);
        two  = W'(2);
        mask = (W'(1) << n) - W'(1);
        inv  = mw;
        for (int i = 0; i < 11; i++) begin
            inv = (inv * (two - mw * inv)) & mask;
        end
        ab = W'(a) * W'(b);
        u  = ((W'(0) - ab) * inv) & mask;
        t  = (ab + u * mw) >> n;
        if (FULL_SUB && (t >= mw)) begin
            t = t - mw;
        end
        return t[1024:0];
    endfunction

    function automatic logic [1023:0] rand1k();
        logic [1023:0] v;
        for (int i = 0; i < 32; i++) begin
            v[i*32 +: 32] = $urandom;
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1024:0] obs, input logic [1024:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (low 192 bits)", tag, obs[191:0], exp[191:0]);
        end
    endtask

    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m, input string tag);
        logic [1024:0] exp;
        int lat;
        exp = mont_ref(1024'(a), 1024'(b), 1024'(m), N8);
        if8.in_a  = a;
        if8.in_b  = b;
        if8.in_m  = m;
        if8.start = 1'b1;
        step();
        if8.start = 1'b0;
        chk({tag, "_done_low_after_accept"}, 1025'(if8.done), 1025'(0));
        chk({tag, "_result_held"}, 1025'(if8.result), 1025'(prev8));
        lat = 0;
        for (int k = 1; k <= N8 + 10; k++) begin
            step();
            if (if8.done === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_latency"}, 1025'(lat), 1025'(N8 + EXTRA));
        chk({tag, "_result"}, 1025'(if8.result), exp);
        prev8 = exp[7:0];
    endtask

    task automatic do_op1k(input logic [1023:0] a, input logic [1023:0] b, input logic [1023:0] m, input string tag);
        logic [1024:0] exp;
        int lat;
        exp = mont_ref(a, b, m, N1K);
        if1k.in_a  = a;
        if1k.in_b  = b;
        if1k.in_m  = m;
        if1k.start = 1'b1;
        step();
        if1k.start = 1'b0;
        chk({tag, "_result_held"}, 1025'(if1k.result), 1025'(prev1k));
        lat = 0;
        for (int k = 1; k <= N1K + 10; k++) begin
            step();
            if (if1k.done === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_latency"}, 1025'(lat), 1025'(N1K + EXTRA));
        chk({tag, "_result"}, 1025'(if1k.result), exp);
        prev1k = exp[1023:0];
    endtask

    initial begin
        logic [7:0]    a8, b8, m8;
        logic [1023:0] m1k, a1k, x1k;
        logic [1024:0] r1k, exp;
        int ndone, lat;

        if8.start  = 1'b0;
        if8.in_a   = '0;
        if8.in_b   = '0;
        if8.in_m   = '0;
        if1k.start = 1'b0;
        if1k.in_a  = '0;
        if1k.in_b  = '0;
        if1k.in_m  = '0;
        rst8_n  = 1'b0;
        rst1k_n = 1'b0;
        prev8   = 8'd0;
        prev1k  = '0;
        step();
        step();
        chk("reset_result8", 1025'(if8.result), 1025'(0));
        chk("reset_done8", 1025'(if8.done), 1025'(0));
        chk("reset_result1k", 1025'(if1k.result), 1025'(0));
        chk("reset_done1k", 1025'(if1k.done), 1025'(0));
        rst8_n  = 1'b1;
        rst1k_n = 1'b1;
        step();

        // T1: 5*7*2^-8 mod 13 = 1
        do_op8(8'd5, 8'd7, 8'd13, "t1");
        chk("t1_mod", 1025'(if8.result % 8'd13), 1025'(1));
        step();
        chk("t1_done_one_cycle", 1025'(if8.done), 1025'(0));

        // T2 (and T5 shape when unreduced): back-to-back, start in each done cycle
        do_op8(8'd12, 8'd12, 8'd13, "t2a");
        chk("t2a_mod", 1025'(if8.result % 8'd13), 1025'(3));
        do_op8(8'd0, 8'd9, 8'd13, "t2b");
        chk("t2b_mod", 1025'(if8.result % 8'd13), 1025'(0));
        do_op8(8'd1, 8'd1, 8'd13, "t2c");
        chk("t2c_mod", 1025'(if8.result % 8'd13), 1025'(3));

        // Random small vectors, back-to-back
        for (int i = 0; i < 16; i++) begin
            m8 = 8'(2 * $urandom_range(1, FULL_SUB ? 127 : 63) + 1);
            a8 = 8'($urandom_range(0, int'(m8) - 1));
            b8 = 8'($urandom_range(0, int'(m8) - 1));
            do_op8(a8, b8, m8, "rnd8");
        end
        step();

        // T3: start held during LOOP and operands toggled after acceptance
        if8.in_a  = 8'd5;
        if8.in_b  = 8'd7;
        if8.in_m  = 8'd13;
        if8.start = 1'b1;
        step();
        ndone = 0;
        lat   = 0;
        for (int k = 1; k <= N8 + 8; k++) begin
            if8.start = (k >= 3 && k <= 7);
            if8.in_a  = 8'($urandom);
            if8.in_b  = 8'($urandom);
            step();
            if (if8.done === 1'b1) begin
                ndone++;
                if (lat == 0) lat = k;
            end
        end
        if8.start = 1'b0;
        exp = mont_ref(1024'(5), 1024'(7), 1024'(13), N8);
        chk("t3_done_count", 1025'(ndone), 1025'(1));
        chk("t3_latency", 1025'(lat), 1025'(N8 + EXTRA));
        chk("t3_result", 1025'(if8.result), exp);
        chk("t3_mod", 1025'(if8.result % 8'd13), 1025'(1));

        // T4: abort at LOOP iteration 4 -> cleared result, no done
        if8.in_a  = 8'd12;
        if8.in_b  = 8'd11;
        if8.in_m  = 8'd13;
        if8.start = 1'b1;
        step();
        if8.start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
        end
        rst8_n = 1'b0;
        #1;
        chk("t4_reset_result", 1025'(if8.result), 1025'(0));
        chk("t4_reset_done", 1025'(if8.done), 1025'(0));
        step();
        rst8_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < N8 + 6; k++) begin
            step();
            if (if8.done === 1'b1) ndone++;
        end
        chk("t4_no_done", 1025'(ndone), 1025'(0));
        chk("t4_result_zero", 1025'(if8.result), 1025'(0));
        prev8 = 8'd0;
        do_op8(8'd5, 8'd7, 8'd13, "t4_after");
        chk("t4_after_mod", 1025'(if8.result % 8'd13), 1025'(1));
        step();

        // T6: N=1024, A = 2^N mod M gives result congruent to x
        for (int i = 0; i < 50; i++) begin
            m1k = rand1k();
            m1k[1023] = FULL_SUB;
            m1k[1022] = 1'b1;
            m1k[0]    = 1'b1;
            r1k = (1025'(1) << 1024) % {1'b0, m1k};
            a1k = r1k[1023:0];
            x1k = rand1k() % m1k;
            do_op1k(a1k, x1k, m1k, "t6");
            chk("t6_identity", 1025'(if1k.result % m1k), 1025'(x1k));
        end
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
